// File: rtl/grp_wb_arbiter_if.sv
// rtl/grp_wb_arbiter_if.sv - writeback request, register-file write and scoreboard query bundle
interface grp_wb_arbiter_if;
  logic        req0_valid;
  logic [4:0]  req0_addr;
  logic [31:0] req0_data;
  logic        req0_ready;
  logic        req1_valid;
  logic [4:0]  req1_addr;
  logic [31:0] req1_data;
  logic        req1_ready;
  logic        rf_wen;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        sb_set;
  logic [4:0]  sb_set_addr;
  logic [4:0]  q1_addr;
  logic [4:0]  q2_addr;
  logic        q1_busy;
  logic        q2_busy;

  // Arbiter side
  modport slave (
    input  req0_valid, req0_addr, req0_data,
    output req0_ready,
    input  req1_valid, req1_addr, req1_data,
    output req1_ready,
    output rf_wen, rf_waddr, rf_wdata,
    input  sb_set, sb_set_addr, q1_addr, q2_addr,
    output q1_busy, q2_busy
  );

  // Requester / decode / register-file side
  modport master (
    output req0_valid, req0_addr, req0_data,
    input  req0_ready,
    output req1_valid, req1_addr, req1_data,
    input  req1_ready,
    input  rf_wen, rf_waddr, rf_wdata,
    output sb_set, sb_set_addr, q1_addr, q2_addr,
    input  q1_busy, q2_busy
  );
endinterface

// File: rtl/grp_wb_arbiter.sv
// rtl/grp_wb_arbiter.sv - register-file write port arbiter with long-latency scoreboard (option: GRP_WB_RR_EN)
module grp_wb_arbiter #(
  parameter int STARVE_MAX = 4,
  parameter int CNT_W      = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  grp_wb_arbiter_if.slave    bus
);

  logic        w_grant0;
  logic        w_grant1;
  logic        w_xfer0;
  logic        w_xfer1;
  logic [31:0] w_set_mask;
  logic [31:0] w_clr_mask;

  logic [31:0] r_busy;
  logic        r_wen;
  logic [4:0]  r_waddr;
  logic [31:0] r_wdata;

`ifdef GRP_WB_RR_EN
  // r_last1 = 1 means req1 won the last contested transfer; reset value makes req0 go first
  logic r_last1;

  // Round-robin grant: alternate when both request, lone requester always wins
  always_comb begin
    w_grant0 = 1'b0;
    w_grant1 = 1'b0;
    if (bus.req0_valid && bus.req1_valid) begin
      w_grant0 = r_last1;
      w_grant1 = ~r_last1;
    end else begin
      w_grant0 = bus.req0_valid;
      w_grant1 = bus.req1_valid;
    end
  end

  // Last-granted pointer moves only when a transfer actually happens
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last1 <= 1'b1;
    end else if (w_xfer0) begin
      r_last1 <= 1'b0;
    end else if (w_xfer1) begin
      r_last1 <= 1'b1;
    end
  end
`else
  logic [CNT_W-1:0] r_starve_cnt;
  logic             w_forced;

  assign w_forced = bus.req1_valid && (r_starve_cnt == CNT_W'(STARVE_MAX));

  // Fixed priority req0 > req1, except req1 is forced through once starved
  always_comb begin
    w_grant0 = 1'b0;
    w_grant1 = 1'b0;
    if (w_forced) begin
      w_grant1 = 1'b1;
    end else if (bus.req0_valid) begin
      w_grant0 = 1'b1;
    end else begin
      w_grant1 = bus.req1_valid;
    end
  end

  // Starvation counter: counts held-off req1 cycles, saturates, clears on req1 transfer or idle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_starve_cnt <= '0;
    end else if (!bus.req1_valid || w_xfer1) begin
      r_starve_cnt <= '0;
    end else if (r_starve_cnt != CNT_W'(STARVE_MAX)) begin
      r_starve_cnt <= r_starve_cnt + 1'b1;
    end
  end
`endif

  // Ready is forced low while reset is asserted since it is purely combinational
  assign bus.req0_ready = w_grant0 & rst_n;
  assign bus.req1_ready = w_grant1 & rst_n;
  assign w_xfer0        = bus.req0_valid & bus.req0_ready;
  assign w_xfer1        = bus.req1_valid & bus.req1_ready;

  // Registered write stage; writes to r0 are accepted but suppressed
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wen   <= 1'b0;
      r_waddr <= '0;
      r_wdata <= '0;
    end else begin
      r_wen <= 1'b0;
      if (w_xfer0) begin
        r_wen   <= (bus.req0_addr != 5'd0);
        r_waddr <= bus.req0_addr;
        r_wdata <= bus.req0_data;
      end else if (w_xfer1) begin
        r_wen   <= (bus.req1_addr != 5'd0);
        r_waddr <= bus.req1_addr;
        r_wdata <= bus.req1_data;
      end
    end
  end

  assign bus.rf_wen   = r_wen;
  assign bus.rf_waddr = r_waddr;
  assign bus.rf_wdata = r_wdata;

  // Scoreboard masks: r0 is never tracked, only req1 transfers retire entries
  always_comb begin
    w_set_mask = '0;
    w_clr_mask = '0;
    if (bus.sb_set) begin
      w_set_mask[bus.sb_set_addr] = 1'b1;
    end
    if (w_xfer1) begin
      w_clr_mask[bus.req1_addr] = 1'b1;
    end
    w_set_mask[0] = 1'b0;
  end

  // Scoreboard update: clear first, then set, so a same-address set wins
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy <= '0;
    end else begin
      r_busy <= (r_busy & ~w_clr_mask) | w_set_mask;
    end
  end

  assign bus.q1_busy = r_busy[bus.q1_addr];
  assign bus.q2_busy = r_busy[bus.q2_addr];

endmodule
